// File: rtl/cpu_pipe_pkg.sv
// Shared types for CPU pipeline stage registers: stage state encoding and payload width limit.
// No logic; the helper maps a stage state to its held-entry count.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;

    localparam int PIPE_MAX_W = 256;

    function automatic logic [1:0] pipe_occ(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            PS_BUSY: occ = 2'd1;
            PS_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_dreg.sv
// N-bit enabled D register with asynchronous active-low reset to RESET_VAL.
// Latency: one cycle. Backpressure: none; loads only when i_en is high.
module pipe_dreg #(
    parameter int           N         = 64,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Latency: one cycle from in_fire to out_valid. Backpressure: one extra payload lands in skid, in_ready drops the next cycle.
module pipe_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int           N         = 64,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    if (N < 1 || N > PIPE_MAX_W) begin : g_bad_width
        $error("pipe_skid_reg: N out of range");
    end

    pipe_state_t  r_state;
    pipe_state_t  w_state_nxt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [1:0]   r_occ;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_main_en;
    logic         w_skid_en;
    logic [N-1:0] w_main_d;
    logic [N-1:0] w_main_q;
    logic [N-1:0] w_skid_q;

    assign w_in_fire  = in_valid & r_in_ready & ~flush;
    assign w_out_fire = r_out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_en   = 1'b0;
        w_skid_en   = 1'b0;
        w_main_d    = in_data;
        case (r_state)
            PS_EMPTY: begin
                if (w_in_fire) begin
                    w_main_en   = 1'b1;
                    w_state_nxt = PS_BUSY;
                end
            end
            PS_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en   = 1'b1;
                    w_state_nxt = PS_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (w_out_fire) begin
                    w_main_en   = 1'b1;
                    w_main_d    = w_skid_q;
                    w_state_nxt = PS_BUSY;
                end
            end
            default: w_state_nxt = PS_EMPTY;
        endcase
        // Squashed entries need not be promoted; out_data is meaningless once empty.
        if (flush) begin
            w_state_nxt = PS_EMPTY;
            w_main_en   = 1'b0;
        end
    end

    // Handshake flags are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= PS_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != PS_FULL);
            r_out_valid <= (w_state_nxt != PS_EMPTY);
            r_occ       <= pipe_occ(w_state_nxt);
        end
    end

    pipe_dreg #(.N(N), .RESET_VAL(RESET_VAL)) u_main (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    pipe_dreg #(.N(N), .RESET_VAL(RESET_VAL)) u_skid (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_main_q;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three instances (N=64, 256, 1) share control and see matching payloads.
// A capacity-2 FIFO queue models the stage; expected payloads are pushed on accept and compared at the head.
module tb_pipe_skid_reg;

    localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

    typedef struct packed {
        logic [255:0] d256;
        logic [63:0]  d64;
        logic         d1;
    } pl_t;

    logic clk, reset, flush, in_valid, out_ready;
    pl_t  drv;

    logic         in_ready64, out_valid64;
    logic [63:0]  out_data64;
    logic [1:0]   occ64;
    logic         in_ready256, out_valid256;
    logic [255:0] out_data256;
    logic [1:0]   occ256;
    logic         in_ready1, out_valid1;
    logic         out_data1;
    logic [1:0]   occ1;

    pl_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    pipe_skid_reg #(.N(64), .RESET_VAL(RV64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_data(drv.d64), .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .occupancy(occ64)
    );

    pipe_skid_reg #(.N(256)) dut256 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready256),
        .in_data(drv.d256), .out_valid(out_valid256), .out_ready(out_ready), .out_data(out_data256),
        .occupancy(occ256)
    );

    pipe_skid_reg #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(drv.d1), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pl_t mk(input logic [63:0] v);
        pl_t p;
        p.d256 = {4{v}};
        p.d64  = v;
        p.d1   = v[0];
        return p;
    endfunction

    function automatic pl_t mk_rand();
        pl_t p;
        for (int k = 0; k < 8; k++) p.d256[k*32 +: 32] = $urandom();
        p.d64 = {$urandom(), $urandom()};
        p.d1  = 1'($urandom());
        return p;
    endfunction

    // Drives one cycle and advances the reference FIFO; returns 1ns after the edge.
    task automatic tick(input logic iv, input pl_t d, input logic ordy, input logic fl);
        logic m_in_rdy, m_out_vld;
        m_in_rdy  = (sb.size() < 2);
        m_out_vld = (sb.size() > 0);
        in_valid  = iv;
        drv       = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (m_out_vld && ordy) void'(sb.pop_front());
        if (fl) sb.delete();
        if (iv && m_in_rdy && !fl) sb.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; drv = mk(64'hDEAD);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || occ64 !== 2'd0 || out_data64 !== RV64)
            $display("FAIL reset_state: vld=%b rdy=%b occ=%0d data=%h, want vld=0 rdy=1 occ=0 data=%h",
                     out_valid64, in_ready64, occ64, out_data64, RV64);
        else n_pass++;
        n_checks++;
        if (out_data256 !== 256'd0 || out_data1 !== 1'b0 || out_valid256 !== 1'b0 || out_valid1 !== 1'b0)
            $display("FAIL reset_wide: vld256=%b vld1=%b d1=%b d256=%h, want zeros",
                     out_valid256, out_valid1, out_data1, out_data256);
        else n_pass++;
        reset = 1'b1;
        tick(1'b1, mk(64'hDEAD), 1'b0, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b1 || out_data64 !== 64'hDEAD || occ64 !== 2'd1)
            $display("FAIL reset_first_fire: vld=%b data=%h occ=%0d, want vld=1 data=dead occ=1",
                     out_valid64, out_data64, occ64);
        else n_pass++;
        tick(1'b0, mk(64'h0), 1'b1, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b0 || occ64 !== 2'd0 || sb.size() != 0)
            $display("FAIL reset_drain: vld=%b occ=%0d, want vld=0 occ=0", out_valid64, occ64);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, mk(64'(i)), 1'b1, 1'b0);
            n_checks++;
            if (out_valid64 !== 1'b1 || out_data64 !== 64'(i) || occ64 !== 2'd1 || in_ready64 !== 1'b1)
                $display("FAIL stream_%0d: vld=%b data=%h occ=%0d rdy=%b, want vld=1 data=%h occ=1 rdy=1",
                         i, out_valid64, out_data64, occ64, in_ready64, 64'(i));
            else n_pass++;
            n_checks++;
            if (sb.size() == 0 || out_data64 !== sb[0].d64 || out_data256 !== sb[0].d256)
                $display("FAIL stream_sb_%0d: data=%h, want head of queue", i, out_data64);
            else n_pass++;
        end
        tick(1'b0, mk(64'h0), 1'b1, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b0 || occ64 !== 2'd0)
            $display("FAIL stream_drain: vld=%b occ=%0d, want vld=0 occ=0", out_valid64, occ64);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_d[5];
        logic [1:0]  exp_o[5];
        logic        exp_r[5];
        logic        ordy[5];
        logic [63:0] din[5];
        exp_d = '{64'hA, 64'hA, 64'hA, 64'hB, 64'hC};
        exp_o = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ordy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        din   = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC};
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, mk(din[i]), ordy[i], 1'b0);
            n_checks++;
            if (out_valid64 !== 1'b1 || out_data64 !== exp_d[i] || occ64 !== exp_o[i] || in_ready64 !== exp_r[i])
                $display("FAIL bp_step%0d: vld=%b data=%h occ=%0d rdy=%b, want vld=1 data=%h occ=%0d rdy=%b",
                         i, out_valid64, out_data64, occ64, in_ready64, exp_d[i], exp_o[i], exp_r[i]);
            else n_pass++;
        end
        tick(1'b0, mk(64'h0), 1'b1, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b0 || occ64 !== 2'd0 || sb.size() != 0)
            $display("FAIL bp_drain: vld=%b occ=%0d, want vld=0 occ=0 (no duplicate)", out_valid64, occ64);
        else n_pass++;
    endtask

    task automatic test_flush();
        tick(1'b1, mk(64'h5), 1'b0, 1'b0);
        tick(1'b1, mk(64'h6), 1'b0, 1'b0);
        n_checks++;
        if (occ64 !== 2'd2 || in_ready64 !== 1'b0 || out_data64 !== 64'h5)
            $display("FAIL flush_full: occ=%0d rdy=%b data=%h, want occ=2 rdy=0 data=5", occ64, in_ready64, out_data64);
        else n_pass++;
        tick(1'b1, mk(64'h7), 1'b0, 1'b1);
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || occ64 !== 2'd0)
            $display("FAIL flush_squash: vld=%b rdy=%b occ=%0d, want vld=0 rdy=1 occ=0", out_valid64, in_ready64, occ64);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, mk(64'h0), 1'b1, 1'b0);
            n_checks++;
            if (out_valid64 !== 1'b0)
                $display("FAIL flush_no_emit_%0d: vld=%b data=%h, want vld=0", i, out_valid64, out_data64);
            else n_pass++;
        end
        tick(1'b0, mk(64'h0), 1'b1, 1'b1);
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || occ64 !== 2'd0)
            $display("FAIL flush_empty: vld=%b rdy=%b occ=%0d, want vld=0 rdy=1 occ=0", out_valid64, in_ready64, occ64);
        else n_pass++;
        tick(1'b1, mk(64'h8), 1'b1, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b1 || out_data64 !== 64'h8 || occ64 !== 2'd1)
            $display("FAIL flush_recover: vld=%b data=%h occ=%0d, want vld=1 data=8 occ=1", out_valid64, out_data64, occ64);
        else n_pass++;
        tick(1'b0, mk(64'h0), 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        tick(1'b1, mk(64'h11), 1'b0, 1'b0);
        tick(1'b1, mk(64'h12), 1'b0, 1'b0);
        in_valid = 1'b0;
        n_checks++;
        if (occ64 !== 2'd2)
            $display("FAIL areset_fill: occ=%0d, want 2", occ64);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid64 !== 1'b0 || occ64 !== 2'd0 || in_ready64 !== 1'b1 || out_data64 !== RV64)
            $display("FAIL areset_immediate: vld=%b occ=%0d rdy=%b data=%h, want vld=0 occ=0 rdy=1 data=%h",
                     out_valid64, occ64, in_ready64, out_data64, RV64);
        else n_pass++;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1'b0, mk(64'h0), 1'b1, 1'b0);
        n_checks++;
        if (out_valid64 !== 1'b0 || occ64 !== 2'd0)
            $display("FAIL areset_after: vld=%b occ=%0d, want vld=0 occ=0", out_valid64, occ64);
        else n_pass++;
    endtask

    task automatic test_random();
        pl_t        d;
        logic       iv, ordy, fl, ev, er;
        logic [1:0] eo;
        for (int c = 0; c < 10000; c++) begin
            eo = 2'(sb.size());
            ev = (sb.size() > 0);
            er = (sb.size() < 2);
            n_checks++;
            if ({out_valid64, in_ready64, occ64, out_valid256, in_ready256, occ256, out_valid1, in_ready1, occ1}
                    !== {3{ev, er, eo}})
                $display("FAIL rnd_status cyc%0d: v/r/occ 64:%b%b%0d 256:%b%b%0d 1:%b%b%0d, want %b%b%0d",
                         c, out_valid64, in_ready64, occ64, out_valid256, in_ready256, occ256,
                         out_valid1, in_ready1, occ1, ev, er, eo);
            else n_pass++;
            if (ev) begin
                n_checks++;
                if (out_data64 !== sb[0].d64 || out_data256 !== sb[0].d256 || out_data1 !== sb[0].d1)
                    $display("FAIL rnd_data cyc%0d: got %h/%h/%b want %h/%h/%b",
                             c, out_data64, out_data256, out_data1, sb[0].d64, sb[0].d256, sb[0].d1);
                else n_pass++;
            end
            d    = mk_rand();
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 19) == 0);
            tick(iv, d, ordy, fl);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register for the ARM64 pipelined CPU. It generalises the plain enabled N-bit register into a valid/ready stage with a two-entry skid buffer and synchronous flush. Consecutive stages can apply back-pressure (stall) without combinational ready paths and still sustain one transfer per cycle. Instances sit between IF/ID/EX/MEM/WB, carrying each stage's packed control and data bundle.

## Interface
- N, default 64: payload width in bits; legal range 1..256.
- RESET_VAL, default '0: value loaded into both payload registers on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all held entries (branch mispredict / exception).
- in_valid  input  1  upstream presents a payload.
- in_ready  output  1  stage can accept a payload this cycle; driven from state only.
- in_data  input  N  upstream payload.
- out_valid  output  1  out_data holds a valid payload; driven from state only.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  N  payload of the oldest held entry.
- occupancy  output  2  held entries: 0, 1 or 2.

## Operation
- Two payload registers: main (drives out_data) and skid.
- in_fire = in_valid & in_ready & !flush.
- out_fire = out_valid & out_ready.
- States:
  - EMPTY: in_ready=1, out_valid=0, occupancy=0.
  - BUSY: main valid; in_ready=1, out_valid=1, occupancy=1.
  - FULL: main and skid valid; in_ready=0, out_valid=1, occupancy=2.
- EMPTY transitions:
  - in_fire: main<=in_data, go to BUSY.
  - otherwise hold.
- BUSY transitions:
  - in_fire & out_fire: main<=in_data, stay in BUSY.
  - in_fire & !out_fire: skid<=in_data, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - otherwise hold.
- FULL transitions:
  - out_fire: main<=skid, go to BUSY.
  - otherwise hold. in_fire is impossible here because in_ready=0.
- flush=1: next state is EMPTY from any state, regardless of in_valid/out_ready. An out_fire in the flush cycle still counts as a completed transfer downstream. in_data is dropped that cycle.
- Payload registers load only on the events listed above. When out_valid=0, out_data holds its last value and carries no meaning.
- Ordering is strictly FIFO; no payload is ever duplicated or lost except by flush.
- Width rule: payload is passed bit-exact; no sign or zero extension.

## Timing
- Reset (reset=0, asynchronous): state=EMPTY, main=skid=RESET_VAL, out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
- Reset deassertion is sampled synchronously; the first in_fire is possible on the first rising edge with reset=1.
- Latency: payload accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one transfer per cycle in steady state with out_ready=1.
- Back-pressure: out_ready dropping absorbs exactly one extra payload (into skid); in_ready falls one cycle later.
- After FULL drains one entry, in_ready rises the cycle after out_fire.
- in_ready and out_valid are pure register outputs; there is no combinational in→out path.
- Reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.

## Structure
- Shared package cpu_pipe_pkg holds:
  - typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipe_state_t;
  - localparam PIPE_MAX_W = 256.
- One sub-module: pipe_dreg #(N, RESET_VAL), an N-bit enabled D register with asynchronous active-low reset. Instantiate it twice, for main and skid.
- State register and next-state/load-enable logic live in pipe_skid_reg.

## Test plan
- Reset: hold reset=0 with in_valid=1, in_data=0xDEAD → out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL; release → first in_fire on next edge.
- Streaming: N=64, out_ready=1, send 0x1..0x10 back-to-back → 0x1..0x10 emerge in order, one per cycle, one-cycle latency, occupancy stays 1.
- Back-pressure:
  - Stream 0xA, 0xB, 0xC, drop out_ready after 0xA is visible → 0xB enters skid, occupancy=2, in_ready=0, upstream holds 0xC.
  - Raise out_ready → outputs 0xA, 0xB, 0xC, no loss or duplication.
- Flush:
  - In FULL (0x5 main, 0x6 skid), assert flush with in_valid=1, in_data=0x7 → next cycle EMPTY, out_valid=0, in_ready=1; 0x7 never emitted.
  - Flush in EMPTY is a no-op.
- Async reset mid-operation: assert reset between edges while FULL → out_valid=0 and occupancy=0 immediately, before the next edge.
- Random: 10k cycles of random in_valid/out_ready/flush, N=1 and N=256 → scoreboard shows FIFO order and no payload emitted after its flush.
